// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
// Shared definitions for the uart_tx arbiter: FSM state encodings, the
// serializer bit-period default and the UART frame length.
// No ports; imported by the arbiter, its round-robin picker and its bus interface.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    // 10 MHz clock / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 87;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester handshake and the serializer-facing signals of the
// arbiter. Signal names keep the i_/o_ prefixes as seen from the arbiter.
//   i_Req, i_Req_Byte        requester levels and their bytes (byte k = [k])
//   o_Ack, o_Done, o_Err     per-requester pulses and watchdog error pulse
//   o_Busy                   arbiter not idle
//   o_Tx_DV, o_Tx_Byte       to uart_tx i_Tx_DV / i_Tx_Byte
//   i_Tx_Active, i_Tx_Done   from uart_tx o_Tx_Active / o_Tx_Done
// master = arbiter side, slave = requesters + serializer side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       i_Req;
    logic [NUM_REQ-1:0][7:0]  i_Req_Byte;
    logic [NUM_REQ-1:0]       o_Ack;
    logic [NUM_REQ-1:0]       o_Done;
    logic                     o_Err;
    logic                     o_Busy;
    logic                     o_Tx_DV;
    logic [7:0]               o_Tx_Byte;
    logic                     i_Tx_Active;
    logic                     i_Tx_Done;

    modport master (
        input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        output o_Ack, o_Done, o_Err, o_Busy, o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Ack, o_Done, o_Err, o_Busy, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick
// Combinational round-robin search: the winner is the first set bit of req
// found searching upward from last+1, wrapping modulo NUM_REQ.
//   req    in  NUM_REQ  request vector
//   last   in  IDX_W    index of the previous grant
//   valid  out 1        at least one request set
//   grant  out IDX_W    winning index (0 when valid is low)
module uart_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   grant
);
    int best_d;
    int d;

    // Rank every set request by its rotational distance past 'last';
    // the smallest distance wins.
    always_comb begin
        valid  = 1'b0;
        grant  = '0;
        best_d = NUM_REQ;
        d      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[k]) begin
                d = k - int'(last) - 1;
                if (d < 0) d = d + NUM_REQ;
                if (d < best_d) begin
                    best_d = d;
                    grant  = IDX_W'(k);
                    valid  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx serializer between NUM_REQ byte requesters. Grants in
// round-robin order, latches the winner's byte, strobes o_Tx_DV for one cycle,
// waits for i_Tx_Done (or a watchdog expiry), reports back, then idles for a
// guard gap before the next grant.
//   i_Clock  in  sole clock, rising edge
//   i_Rst_n  in  synchronous active-low reset
//   bus      master modport of uart_tx_arbiter_if (requesters + serializer)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_CLKS = (FRAME_BITS + 2) * CLKS_PER_BIT,
    parameter int GAP_CLKS     = 1
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    uart_tx_arbiter_if.master     bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);

    // Expiry is detected on the count that is about to reach TIMEOUT_CLKS-1,
    // which puts o_Err exactly TIMEOUT_CLKS cycles after the DV strobe.
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CLKS - 2);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CLKS);

    state_e                 state_q;
    logic [IDX_W-1:0]       last_q;     // doubles as the current grant index
    logic [WD_W-1:0]        wd_q;
    logic [GAP_W-1:0]       gap_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REQ-1:0]     done_q;
    logic                   err_q;
    logic                   dv_q;
    logic [7:0]             byte_q;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.i_Req),
        .last  (last_q),
        .valid (pick_valid),
        .grant (pick_idx)
    );

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            wd_q    <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
        end else begin
            dv_q   <= 1'b0;
            ack_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Tx_Active guard keeps us off a serializer still busy
                    // with a frame launched before a reset.
                    if (pick_valid && !bus.i_Tx_Active) begin
                        byte_q  <= bus.i_Req_Byte[pick_idx];
                        last_q  <= pick_idx;
                        dv_q    <= 1'b1;
                        ack_q   <= NUM_REQ'(1) << pick_idx;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // done takes priority over a simultaneous expiry
                    if (bus.i_Tx_Done) begin
                        done_q  <= NUM_REQ'(1) << last_q;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_GAP: begin
                    // the done/err cycle plus GAP_CLKS idle clocks
                    if (gap_q == GAP_END) state_q <= S_IDLE;
                    else                  gap_q   <= gap_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_Ack     = ack_q;
    assign bus.o_Done    = done_q;
    assign bus.o_Err     = err_q;
    assign bus.o_Busy    = (state_q != S_IDLE);
    assign bus.o_Tx_DV   = dv_q;
    assign bus.o_Tx_Byte = byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. The bench plays both the requesters and
// a stub serializer (Tx_Active / Tx_Done driven by hand). Inputs change and
// outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;
    localparam int NR  = 2;
    localparam int TO  = 20;
    localparam int GAP = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .CLKS_PER_BIT(87), .TIMEOUT_CLKS(TO), .GAP_CLKS(GAP)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Waits up to 40 cycles for a DV strobe; n = falling edges waited.
    task automatic wait_dv(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) begin
                ok = 1'b1;
                n  = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok; int n;
        rst_n = 1'b0;
        bus.i_Req = 2'b11;
        bus.i_Req_Byte = {8'hC3, 8'h4B};
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({bus.o_Ack, bus.o_Done, bus.o_Err, bus.o_Busy, bus.o_Tx_DV, bus.o_Tx_Byte} !== 15'd0) begin
                bad++;
                $display("FAIL reset_outputs: cycle %0d ack=%b done=%b err=%b busy=%b dv=%b byte=%h, want all 0",
                         c, bus.o_Ack, bus.o_Done, bus.o_Err, bus.o_Busy, bus.o_Tx_DV, bus.o_Tx_Byte);
            end
        end
        rst_n = 1'b1;
        wait_dv(ok, n);
        total++;
        if (!ok || n != 1 || bus.o_Ack !== 2'b01 || bus.o_Tx_Byte !== 8'h4B || bus.o_Busy !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: ok=%0d n=%0d ack=%b byte=%h busy=%b, want n=1 ack=01 byte=4b busy=1",
                     ok, n, bus.o_Ack, bus.o_Tx_Byte, bus.o_Busy);
        end
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_Tx_DV !== 1'b0 || bus.o_Ack !== 2'b00) begin
            bad++;
            $display("FAIL dv_single_cycle: dv=%b ack=%b, want 0 00", bus.o_Tx_DV, bus.o_Ack);
        end
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        bus.i_Tx_Active = 1'b0;
        total++;
        if (bus.o_Done !== 2'b01) begin
            bad++;
            $display("FAIL reset_frame_done: done=%b, want 01", bus.o_Done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok; int n; int dvs;
        bus.i_Req_Byte = {8'h3A, 8'h00};
        bus.i_Req = 2'b10;
        wait_dv(ok, n);
        total++;
        if (!ok || bus.o_Ack !== 2'b10 || bus.o_Tx_Byte !== 8'h3A) begin
            bad++;
            $display("FAIL single_grant: ok=%0d ack=%b byte=%h, want ack=10 byte=3a", ok, bus.o_Ack, bus.o_Tx_Byte);
        end
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        dvs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) dvs++;
        end
        total++;
        if (dvs != 0 || bus.o_Tx_Byte !== 8'h3A) begin
            bad++;
            $display("FAIL single_extra_dv: extra dv=%0d byte=%h, want 0 and 3a", dvs, bus.o_Tx_Byte);
        end
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        bus.i_Tx_Active = 1'b0;
        total++;
        if (bus.o_Done !== 2'b10 || bus.o_Err !== 1'b0) begin
            bad++;
            $display("FAIL single_done: done=%b err=%b, want 10 0", bus.o_Done, bus.o_Err);
        end
        @(negedge clk);
        total++;
        if (bus.o_Done !== 2'b00) begin
            bad++;
            $display("FAIL single_done_pulse: done=%b, want 00", bus.o_Done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit ok; int n; int exp_k;
        logic [7:0] exp_b;
        bus.i_Req_Byte = {8'hB1, 8'hA0};
        bus.i_Req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_k = f % 2;              // last grant was req1
            exp_b = (exp_k == 0) ? 8'hA0 : 8'hB1;
            wait_dv(ok, n);
            total++;
            if (!ok || bus.o_Ack !== (2'b01 << exp_k) || bus.o_Tx_Byte !== exp_b) begin
                bad++;
                $display("FAIL rr_grant%0d: ok=%0d ack=%b byte=%h, want ack=%b byte=%h",
                         f, ok, bus.o_Ack, bus.o_Tx_Byte, 2'b01 << exp_k, exp_b);
            end
            if (f > 0) begin
                total++;
                if (n != GAP + 2) begin
                    bad++;
                    $display("FAIL rr_spacing%0d: done->ack %0d cycles, want %0d", f, n, GAP + 2);
                end
            end
            bus.i_Req[exp_k] = 1'b0;
            bus.i_Tx_Active = 1'b1;
            repeat (3) @(negedge clk);
            bus.i_Tx_Done = 1'b1;
            @(negedge clk);
            bus.i_Tx_Done = 1'b0;
            bus.i_Tx_Active = 1'b0;
            total++;
            if (bus.o_Done !== (2'b01 << exp_k)) begin
                bad++;
                $display("FAIL rr_done%0d: done=%b, want %b", f, bus.o_Done, 2'b01 << exp_k);
            end
            if (f < 3) bus.i_Req[exp_k] = 1'b1;
        end
        bus.i_Req = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_watchdog();
        bit ok; int n;
        bus.i_Req_Byte = {8'h00, 8'h4B};
        bus.i_Req = 2'b01;
        wait_dv(ok, n);
        total++;
        if (!ok || bus.o_Ack !== 2'b01) begin
            bad++;
            $display("FAIL wd_grant: ok=%0d ack=%b, want ack=01", ok, bus.o_Ack);
        end
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 22) bus.i_Tx_Active = 1'b0;
            total++;
            if (bus.o_Err !== (i == TO) || bus.o_Done !== 2'b00) begin
                bad++;
                $display("FAIL wd_err_cycle%0d: err=%b done=%b, want err=%0d done=00", i, bus.o_Err, bus.o_Done, i == TO);
            end
        end
        total++;
        if (bus.o_Busy !== 1'b0) begin
            bad++;
            $display("FAIL wd_back_idle: busy=%b, want 0", bus.o_Busy);
        end
    endtask

    task automatic test_race();
        bit ok; int n;
        bus.i_Req_Byte = {8'h77, 8'h00};
        bus.i_Req = 2'b10;
        wait_dv(ok, n);
        total++;
        if (!ok || bus.o_Ack !== 2'b10) begin
            bad++;
            $display("FAIL race_grant: ok=%0d ack=%b, want ack=10", ok, bus.o_Ack);
        end
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        repeat (TO - 1) @(negedge clk);
        bus.i_Tx_Done = 1'b1;           // sampled on the expiry edge
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        bus.i_Tx_Active = 1'b0;
        total++;
        if (bus.o_Done !== 2'b10 || bus.o_Err !== 1'b0) begin
            bad++;
            $display("FAIL race_done_wins: done=%b err=%b, want 10 0", bus.o_Done, bus.o_Err);
        end
        @(negedge clk);
        total++;
        if (bus.o_Err !== 1'b0) begin
            bad++;
            $display("FAIL race_no_late_err: err=%b, want 0", bus.o_Err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit ok; int n; int dvs;
        bus.i_Req_Byte = {8'h00, 8'h11};
        bus.i_Req = 2'b01;
        wait_dv(ok, n);
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_Req_Byte = {8'h00, 8'h5C};
        bus.i_Req = 2'b01;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_Busy !== 1'b0 || bus.o_Tx_DV !== 1'b0 || bus.o_Tx_Byte !== 8'h00) begin
            bad++;
            $display("FAIL midreset_state: busy=%b dv=%b byte=%h, want 0 0 00", bus.o_Busy, bus.o_Tx_DV, bus.o_Tx_Byte);
        end
        rst_n = 1'b1;
        dvs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.o_Tx_DV !== 1'b0) dvs++;
        end
        total++;
        if (dvs != 0 || bus.o_Busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_blocked: dv count=%0d busy=%b while active, want 0 0", dvs, bus.o_Busy);
        end
        bus.i_Tx_Active = 1'b0;
        wait_dv(ok, n);
        total++;
        if (!ok || n != 1 || bus.o_Ack !== 2'b01 || bus.o_Tx_Byte !== 8'h5C) begin
            bad++;
            $display("FAIL midreset_grant: ok=%0d n=%0d ack=%b byte=%h, want n=1 ack=01 byte=5c",
                     ok, n, bus.o_Ack, bus.o_Tx_Byte);
        end
        bus.i_Req = 2'b00;
        bus.i_Tx_Active = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_Tx_Done = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done = 1'b0;
        bus.i_Tx_Active = 1'b0;
        total++;
        if (bus.o_Done !== 2'b01) begin
            bad++;
            $display("FAIL midreset_done: done=%b, want 01", bus.o_Done);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_race();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
